pdcch_qpsk_mapper: RTL



---
 rtl/pdcch_pkg.sv | 21 ++
 rtl/qpsk_sym_map.sv | 17 +
 rtl/pdcch_qpsk_mapper.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pdcch_pkg.sv
// Shared types and constants for the PDCCH QPSK mapping stage.
package pdcch_pkg;

    localparam int DATA_IN_WIDTH    = 8;
    localparam int IQ_WIDTH_DEFAULT = 16;
    localparam int FRAME_W_DEFAULT  = 16;

    // round(2^15 / sqrt(2)): unit-power QPSK in Q1.15
    localparam logic signed [IQ_WIDTH_DEFAULT-1:0] QPSK_AMP_DEFAULT = 16'sd23170;

    typedef struct packed {
        logic signed [IQ_WIDTH_DEFAULT-1:0] q;
        logic signed [IQ_WIDTH_DEFAULT-1:0] i;
    } iq_sample_t;

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } qpsk_state_e;

endpackage

// File: rtl/qpsk_sym_map.sv
// Combinational QPSK lookup: bit pair {b1,b0} -> packed {Q,I}, a set bit maps to -QPSK_AMP.
module qpsk_sym_map #(
    parameter int                          IQ_WIDTH = 16,
    parameter logic signed [IQ_WIDTH-1:0]  QPSK_AMP = 16'sd23170
) (
    input  logic [1:0]            bits,
    output logic [2*IQ_WIDTH-1:0] sym
);

    logic signed [IQ_WIDTH-1:0] sym_i;
    logic signed [IQ_WIDTH-1:0] sym_q;

    assign sym_i = bits[0] ? -QPSK_AMP : QPSK_AMP;
    assign sym_q = bits[1] ? -QPSK_AMP : QPSK_AMP;
    assign sym   = {sym_q, sym_i};

endmodule

// File: rtl/pdcch_qpsk_mapper.sv
// PDCCH QPSK mapper: one scrambled byte in, four {Q,I} symbols out, bit0 first.
// Optional frame tlast generation is built when PDCCH_QPSK_LAST_EN is defined.
module pdcch_qpsk_mapper
    import pdcch_pkg::*;
#(
    parameter int                         DATA_IN_WIDTH = 8,
    parameter int                         IQ_WIDTH      = 16,
    parameter logic signed [IQ_WIDTH-1:0] QPSK_AMP      = QPSK_AMP_DEFAULT,
    parameter int                         FRAME_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_IN_WIDTH-1:0] s_axis_qpsk_data,
    input  logic                     s_axis_qpsk_valid,
    output logic                     s_axis_qpsk_ready,
    input  logic [FRAME_W-1:0]       cfg_frame_syms,
    output logic [2*IQ_WIDTH-1:0]    m_axis_qpsk_data,
    output logic                     m_axis_qpsk_valid,
    input  logic                     m_axis_qpsk_ready,
    output logic                     m_axis_qpsk_last,
    output qpsk_state_e              dbg_state,
    output logic [1:0]               dbg_sym_idx
);

    // Handshake rule on both sides: a beat transfers on a rising clk edge where
    // valid & ready are both high; valid and payload hold steady until it does.

    qpsk_state_e               state;
    logic                      ready_en;
    logic [1:0]                sym_idx;
    logic [DATA_IN_WIDTH-1:0]  byte_q;
    logic [2*IQ_WIDTH-1:0]     data_q;
    logic [1:0]                next_bits;
    logic [2*IQ_WIDTH-1:0]     first_sym;
    logic [2*IQ_WIDTH-1:0]     next_sym;
    logic                      in_hs;
    logic                      out_hs;

    // Input is taken when idle, or in the same cycle the final symbol leaves.
    assign s_axis_qpsk_ready = ready_en & ((state == EMPTY) |
                               ((sym_idx == 2'd3) & m_axis_qpsk_ready));
    assign m_axis_qpsk_valid = (state == BUSY);
    assign m_axis_qpsk_data  = data_q;
    assign in_hs             = s_axis_qpsk_valid & s_axis_qpsk_ready;
    assign out_hs            = m_axis_qpsk_valid & m_axis_qpsk_ready;
    assign dbg_state         = state;
    assign dbg_sym_idx       = sym_idx;

    always_comb begin
        next_bits = 2'b00;
        case (sym_idx)
            2'd0:    next_bits = byte_q[3:2];
            2'd1:    next_bits = byte_q[5:4];
            2'd2:    next_bits = byte_q[7:6];
            default: next_bits = 2'b00;
        endcase
    end

    qpsk_sym_map #(.IQ_WIDTH(IQ_WIDTH), .QPSK_AMP(QPSK_AMP)) u_map_first (
        .bits (s_axis_qpsk_data[1:0]),
        .sym  (first_sym)
    );

    qpsk_sym_map #(.IQ_WIDTH(IQ_WIDTH), .QPSK_AMP(QPSK_AMP)) u_map_next (
        .bits (next_bits),
        .sym  (next_sym)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= EMPTY;
            ready_en <= 1'b0;
            sym_idx  <= 2'd0;
            byte_q   <= '0;
            data_q   <= '0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                EMPTY: begin
                    if (in_hs) begin
                        byte_q  <= s_axis_qpsk_data;
                        sym_idx <= 2'd0;
                        data_q  <= first_sym;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (out_hs) begin
                        if (sym_idx != 2'd3) begin
                            sym_idx <= sym_idx + 2'd1;
                            data_q  <= next_sym;
                        end else if (in_hs) begin
                            byte_q  <= s_axis_qpsk_data;
                            sym_idx <= 2'd0;
                            data_q  <= first_sym;
                        end else begin
                            sym_idx <= 2'd0;
                            state   <= EMPTY;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef PDCCH_QPSK_LAST_EN
    logic [FRAME_W-1:0] frame_cnt;
    logic [FRAME_W-1:0] frame_len;
    logic [FRAME_W-1:0] frame_cnt_next;
    logic [FRAME_W-1:0] cfg_len;

    // A zero-length frame would never terminate, so it behaves as length 1.
    assign cfg_len          = (cfg_frame_syms == '0) ? {{(FRAME_W-1){1'b0}}, 1'b1} : cfg_frame_syms;
    assign m_axis_qpsk_last = (state == BUSY) & (frame_cnt == frame_len - 1'b1);

    always_comb begin
        frame_cnt_next = frame_cnt;
        if (out_hs)
            frame_cnt_next = m_axis_qpsk_last ? '0 : frame_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            frame_len <= {{(FRAME_W-1){1'b0}}, 1'b1};
        end else begin
            frame_cnt <= frame_cnt_next;
            if (in_hs && frame_cnt_next == '0)
                frame_len <= cfg_len;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg       = ^cfg_frame_syms;
    assign m_axis_qpsk_last = 1'b0;
`endif

endmodule
